// File: rtl/mux_sel_sequencer_if.sv
// Control and select bundle between a camera-stream host and mux_sel_sequencer.
// The host (master) sets mode/request/mask and frame timing; the sequencer (slave) returns the select.
interface mux_sel_sequencer_if;
    logic       mode;
    logic [1:0] req_sel;
    logic [3:0] enable_mask;
    logic       frame_start;
    logic [1:0] sel;
    logic       sel_valid;
    logic       switch_pulse;

    modport master (
        output mode, req_sel, enable_mask, frame_start,
        input  sel, sel_valid, switch_pulse
    );

    modport slave (
        input  mode, req_sel, enable_mask, frame_start,
        output sel, sel_valid, switch_pulse
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Frame-aligned 2-bit select generator for a 4:1 camera-stream mux.
// The source is chosen manually or by round-robin scan, and it only moves on frame_start.
module mux_sel_sequencer #(
    parameter int FRAME_HOLD = 1,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_sel_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SWITCH, HOLD} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FRAME_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic       mask_any;
    logic       cur_enabled;
    logic       req_enabled;
    logic [1:0] lowest_idx;
    logic [1:0] next_idx;
    logic       sel_valid_d;
    logic       switch_pulse_d;

    function automatic logic [1:0] lowest_enabled(input logic [3:0] mask);
        logic [1:0] res;
        res = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) res = 2'(k);
        end
        return res;
    endfunction

    // Walk from the farthest offset inward so the nearest enabled index after cur wins.
    function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] res;
        logic [1:0] idx;
        res = cur;
        for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    assign mask_any    = |bus.enable_mask;
    assign cur_enabled = bus.enable_mask[sel_q];
    assign req_enabled = bus.enable_mask[bus.req_sel];
    assign lowest_idx  = lowest_enabled(bus.enable_mask);
    assign next_idx    = next_enabled(sel_q, bus.enable_mask);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        if (!mask_any) begin
            // An empty mask overrides everything, including a coincident frame_start.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        state_d    = SWITCH;
                        sel_d      = (!bus.mode && req_enabled) ? bus.req_sel : lowest_idx;
                        hold_cnt_d = '0;
                    end
                end
                SWITCH: begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
                HOLD: begin
                    if (bus.frame_start) begin
                        if (!bus.mode) begin
                            if (bus.req_sel != sel_q && req_enabled) begin
                                state_d = SWITCH;
                                sel_d   = bus.req_sel;
                            end else if (!cur_enabled) begin
                                state_d = SWITCH;
                                sel_d   = lowest_idx;
                            end
                        end else if (hold_cnt_q == HOLD_LAST || !cur_enabled) begin
                            hold_cnt_d = '0;
                            if (next_idx != sel_q) begin
                                state_d = SWITCH;
                                sel_d   = next_idx;
                            end
                        end else if (hold_cnt_q < HOLD_LAST) begin
                            hold_cnt_d = hold_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic; sel_valid follows the mask combinationally so a disabled source drops at once.
    always_comb begin
        sel_valid_d    = 1'b0;
        switch_pulse_d = 1'b0;
        case (state_q)
            SWITCH:  switch_pulse_d = 1'b1;
            HOLD:    sel_valid_d    = cur_enabled;
            default: ;
        endcase
    end

    assign bus.sel          = sel_q;
    assign bus.sel_valid    = sel_valid_d;
    assign bus.switch_pulse = switch_pulse_d;

endmodule
